// File: rtl/multi_seq.sv
// multi_seq: sequential shift-add multiplier with an input operand FIFO,
// per-operation signed/unsigned mode and valid/ready handshakes on both sides.
// Produces a full-width 2*DATA_W product after DATA_W iteration cycles.
// Optional feature macro: MULTI_SEQ_EARLY_DONE_EN -- when defined, an
// operation leaves the iteration phase as soon as the remaining multiplier
// bits are all zero, so short multipliers finish early with identical results.
module multi_seq #(
    parameter int DATA_W   = 8,
    parameter int FIFO_DEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic                  in_signed,
    input  logic [DATA_W-1:0]     in0_data,
    input  logic [DATA_W-1:0]     in1_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  multi_busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int AW     = $clog2(FIFO_DEP);
    localparam int ENT_W  = 2 * DATA_W + 1;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of an operand; the most-negative value maps to 2^(DATA_W-1),
    // which still fits in DATA_W unsigned bits.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic             sgn);
        return (sgn && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

    // Re-apply the product sign to the unsigned accumulator (mod 2^PROD_W).
    function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] mag,
                                                     input logic              neg);
        return neg ? (~mag + PROD_W'(1)) : mag;
    endfunction

    state_t               state, state_nxt;

    logic [ENT_W-1:0]     fifo_mem [FIFO_DEP];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic [ENT_W-1:0]     head;
    logic                 head_signed;
    logic [DATA_W-1:0]    head_in0, head_in1;

    logic                 neg;
    logic [PROD_W-1:0]    mcand;
    logic [DATA_W-1:0]    mplier;
    logic [PROD_W-1:0]    acc, acc_next;
    logic [CNT_W-1:0]     cnt;
    logic                 calc_last;

    // FIFO status: extra pointer bit distinguishes full from empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_rdy     = ~fifo_full;
    assign push       = in_vld & ~fifo_full;
    assign pop        = (state == IDLE) & ~fifo_empty;

    assign head        = fifo_mem[rd_ptr[AW-1:0]];
    assign head_signed = head[ENT_W-1];
    assign head_in0    = head[2*DATA_W-1:DATA_W];
    assign head_in1    = head[DATA_W-1:0];

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {in_signed, in0_data, in1_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

`ifdef MULTI_SEQ_EARLY_DONE_EN
    assign calc_last = (cnt == CNT_W'(DATA_W-1)) || (mplier[DATA_W-1:1] == '0);
`else
    assign calc_last = (cnt == CNT_W'(DATA_W-1));
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = CALC;
            CALC:    if (calc_last)   state_nxt = DONE;
            DONE:    if (out_rdy)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        out_vld    = (state == DONE);
        multi_busy = ~fifo_empty | (state != IDLE);
    end

    // Iteration datapath: load on pop, shift-add each CALC cycle
    always_ff @(posedge clk) begin
        if (pop) begin
            neg    <= head_signed & (head_in0[DATA_W-1] ^ head_in1[DATA_W-1]);
            mcand  <= {{DATA_W{1'b0}}, magnitude(head_in0, head_signed)};
            mplier <= magnitude(head_in1, head_signed);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Product register: captured on the final iteration, held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if ((state == CALC) && calc_last) begin
            out_data <= apply_sign(acc_next, neg);
        end
    end

endmodule

// File: tb/tb_multi_seq.sv
// tb_multi_seq: directed and randomized checks of multi_seq against a
// plain-arithmetic product model and a latency model derived from operand bits.
module tb_multi_seq;

    localparam int DATA_W   = 8;
    localparam int FIFO_DEP = 4;
    localparam int PW       = 2 * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic              in_signed = 1'b0;
    logic [DATA_W-1:0] in0_data = '0;
    logic [DATA_W-1:0] in1_data = '0;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic [PW-1:0]     out_data;
    logic              multi_busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multi_seq #(.DATA_W(DATA_W), .FIFO_DEP(FIFO_DEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_signed  (in_signed),
        .in0_data   (in0_data),
        .in1_data   (in1_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .multi_busy (multi_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference product: ordinary integer multiplication, truncated to PW bits
    function automatic logic [PW-1:0] ref_prod(input logic s, input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        longint va, vb, p;
        va = s ? longint'($signed(a)) : longint'(a);
        vb = s ? longint'($signed(b)) : longint'(b);
        p  = va * vb;
        return PW'(p);
    endfunction

    // Number of iteration cycles expected for a given multiplier
    function automatic int ref_calc(input logic s, input logic [DATA_W-1:0] b);
        int m, hi, early;
        m  = (s && b[DATA_W-1]) ? ((1 << DATA_W) - int'(b)) : int'(b);
        hi = -1;
        for (int i = 0; i < 32; i++) if ((m >> i) & 1) hi = i;
        early = (hi + 1 < 1) ? 1 : hi + 1;
`ifdef MULTI_SEQ_EARLY_DONE_EN
        return early;
`else
        return (early > 0) ? DATA_W : DATA_W;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated operation; the push edge counts as cycle 0
    task automatic run_op(input string tag, input logic s, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b);
        int n;
        @(negedge clk);
        in_vld = 1'b1; in_signed = s; in0_data = a; in1_data = b; out_rdy = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_vld = 1'b0;
        while (!out_vld && n < 200) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check({tag, " latency"}, n, 2 + ref_calc(s, b));
        check({tag, " product"}, out_data, ref_prod(s, a, b));
        @(posedge clk);
        @(negedge clk);
        check({tag, " vld after"}, out_vld, 1'b0);
        check({tag, " busy after"}, multi_busy, 1'b0);
    endtask

    initial begin
        logic [PW-1:0]     q[$];
        int                cq[$];
        logic              s;
        logic [DATA_W-1:0] a, b;
        int                cyc, last, pushes;
        logic              seen;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_rdy", in_rdy, 1'b1);
        check("rst out_vld", out_vld, 1'b0);
        check("rst out_data", out_data, '0);
        check("rst busy", multi_busy, 1'b0);
        rst_n = 1'b1;

        // Directed products and latency
        run_op("u200x255", 1'b0, 8'd200, 8'd255);
        run_op("s-3x5",    1'b1, 8'hFD,  8'h05);
        run_op("s-128x-128", 1'b1, 8'h80, 8'h80);
        run_op("s127x-128", 1'b1, 8'h7F, 8'h80);
        run_op("u128x128", 1'b0, 8'h80,  8'h80);
        run_op("u7x2",     1'b0, 8'd7,   8'd2);
        run_op("u9x0",     1'b0, 8'd9,   8'd0);
        run_op("s-1x-1",   1'b1, 8'hFF,  8'hFF);
        run_op("uFFxFF",   1'b0, 8'hFF,  8'hFF);

        // Backpressure: out_rdy low, in_vld held high
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp in_rdy", in_rdy, (i < 5));
            s = 1'(($urandom) & 1); a = DATA_W'($urandom); b = DATA_W'($urandom);
            in_vld = 1'b1; in_signed = s; in0_data = a; in1_data = b;
            if (i < 5) begin
                q.push_back(ref_prod(s, a, b));
                cq.push_back(ref_calc(s, b));
            end
        end
        @(negedge clk);
        in_vld = 1'b0;
        check("bp busy", multi_busy, 1'b1);
        out_rdy = 1'b1;
        cyc = 0; last = -1;
        while (q.size() > 0 && cyc < 500) begin
            if (out_vld) begin
                check("bp product", out_data, q.pop_front());
                if (last >= 0) check("bp spacing", cyc - last, 2 + cq[0]);
                void'(cq.pop_front());
                last = cyc;
            end
            @(posedge clk); @(negedge clk); cyc++;
        end
        check("bp drained", q.size(), 0);
        q.delete(); cq.delete();

        // Reset in the middle of CALC with two entries queued
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_vld = 1'b1; in_signed = 1'b0; in0_data = 8'd50 + DATA_W'(i); in1_data = 8'hFF;
        end
        @(negedge clk);
        in_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid-rst out_vld", out_vld, 1'b0);
        check("mid-rst in_rdy", in_rdy, 1'b1);
        check("mid-rst busy", multi_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | out_vld | multi_busy;
        end
        check("mid-rst no output", seen, 1'b0);

        // Randomized traffic with random backpressure
        do_reset();
        pushes = 0; cyc = 0;
        while ((pushes < 40 || q.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            out_rdy = ($urandom_range(0, 3) != 0);
            if (out_vld && out_rdy) begin
                if (q.size() > 0) check("rand product", out_data, q.pop_front());
                else check("rand unexpected output", 1'b1, 1'b0);
            end
            s = 1'(($urandom) & 1); a = DATA_W'($urandom); b = DATA_W'($urandom);
            if ($urandom_range(0, 7) == 0) b = DATA_W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 8'h80;
            in_vld = (pushes < 40) && ($urandom_range(0, 1) == 1);
            in_signed = s; in0_data = a; in1_data = b;
            if (in_vld && in_rdy) begin
                q.push_back(ref_prod(s, a, b));
                pushes++;
            end
        end
        @(negedge clk);
        in_vld = 1'b0;
        check("rand drained", q.size(), 0);
        check("rand pushes", pushes, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "time limit");
    end

endmodule
